// File: rtl/mem_access_unit_pkg.sv
// Shared codes for the memory-stage load/store unit: opcodes, funct3
// values, bus direction, access sizes, FSM states and the size decoder.
package mem_access_unit_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef struct packed {
        size_e size;
        logic  uns;
    } acc_t;

    // Any encoding not legal for the datapath width falls back to a
    // signed word access.
    function automatic acc_t decode_acc(
        input logic [2:0] f3,
        input logic       store,
        input logic       rv64
    );
        acc_t a;
        a.size = SZ_W;
        a.uns  = 1'b0;
        if (store) begin
            case ({1'b0, f3[1:0]})
                F3_SB:   a.size = SZ_B;
                F3_SH:   a.size = SZ_H;
                F3_SW:   a.size = SZ_W;
                F3_SD:   a.size = rv64 ? SZ_D : SZ_W;
                default: a.size = SZ_W;
            endcase
        end else begin
            case (f3)
                F3_LB:  a.size = SZ_B;
                F3_LH:  a.size = SZ_H;
                F3_LW:  a.size = SZ_W;
                F3_LD:  a.size = rv64 ? SZ_D : SZ_W;
                F3_LBU: begin a.size = SZ_B; a.uns = 1'b1; end
                F3_LHU: begin a.size = SZ_H; a.uns = 1'b1; end
                F3_LWU: begin a.size = SZ_W; a.uns = 1'b1; end
                default: a.size = SZ_W;
            endcase
        end
        return a;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-outstanding valid/ack data-memory port.
// master: mem_req/we/addr/be/wdata out, mem_ack/rdata in; slave mirrors it.
interface mem_access_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN/8-1:0]   mem_be;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_ack;
    logic [XLEN-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: size/offset -> misalignment, byte enables, shifted
// store data and extracted, sign/zero-extended load data. Purely combinational.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB  = XLEN / 8,
    localparam int OW  = $clog2(NB)
) (
    input  size_e           size,
    input  logic [OW-1:0]   offset,
    input  logic            sign,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic            misaligned,
    output logic [NB-1:0]   be,
    output logic [XLEN-1:0] wdata_lane,
    output logic [XLEN-1:0] rdata_ext
);

    logic [OW+2:0]   bit_off;
    logic [NB-1:0]   be_base;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] shifted;
    logic            sbit;

    assign bit_off = {offset, 3'b000};

    always_comb begin
        be_base    = '0;
        mask       = '0;
        sbit       = 1'b0;
        misaligned = 1'b0;
        shifted    = rdata >> bit_off;
        unique case (size)
            SZ_B: begin
                be_base = NB'(1);
                mask    = XLEN'(8'hFF);
                sbit    = shifted[7];
            end
            SZ_H: begin
                be_base    = NB'(3);
                mask       = XLEN'(16'hFFFF);
                sbit       = shifted[15];
                misaligned = offset[0];
            end
            SZ_W: begin
                be_base    = NB'(4'hF);
                mask       = XLEN'(32'hFFFF_FFFF);
                sbit       = shifted[31];
                misaligned = |offset[1:0];
            end
            SZ_D: begin
                be_base    = '1;
                mask       = '1;
                sbit       = shifted[XLEN-1];
                misaligned = |offset;
            end
        endcase
        be         = be_base << offset;
        wdata_lane = wdata << bit_off;
        // Bits above the access width are filled with the sign bit
        // only for signed loads.
        rdata_ext  = (shifted & mask) | ((sign && sbit) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: decodes LOAD/STORE, traps misalignment,
// drives one outstanding request on bus, times out a missing ack and
// returns the extended load result with a one-cycle done pulse.
// Ports: clock/reset; req_valid/req_ready/inst/addr/wdata from the pipeline;
// bus (master modport); done/rdata/exc_misaligned/exc_bus back to it.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       inst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    mem_access_unit_if.master bus,
    output logic              done,
    output logic [XLEN-1:0]   rdata,
    output logic              exc_misaligned,
    output logic              exc_bus
);

    localparam int NB    = XLEN / 8;
    localparam int OW    = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic RV64 = (XLEN == 64);

    state_e            state;
    state_e            state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     be_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              we_q;
    size_e             size_q;
    logic              uns_q;
    logic [OW-1:0]     off_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              exc_mis_q;
    logic              exc_bus_q;

    logic              is_load;
    logic              is_store;
    logic              accept;
    logic              timeout_hit;
    logic              in_req;
    acc_t              acc;
    logic              unused_inst;

    size_e             al_size;
    logic [OW-1:0]     al_off;
    logic              al_sign;
    logic              al_mis;
    logic [NB-1:0]     al_be;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;

    assign is_load     = (inst[6:0] == OP_LOAD);
    assign is_store    = (inst[6:0] == OP_STORE);
    assign acc         = decode_acc(inst[14:12], is_store, RV64);
    assign unused_inst = ^{inst[31:15], inst[11:7]};

    assign req_ready   = (state == S_IDLE);
    assign accept      = req_valid && req_ready && (is_load || is_store);
    assign cnt_inc     = cnt + CNT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

    // One aligner serves both phases: the incoming request while idle
    // (enables, store data, misalignment) and the latched access while
    // waiting (load extraction).
    assign al_size = (state == S_IDLE) ? acc.size : size_q;
    assign al_off  = (state == S_IDLE) ? addr[OW-1:0] : off_q;
    assign al_sign = (state == S_IDLE) ? !acc.uns : !uns_q;

    mem_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .size       (al_size),
        .offset     (al_off),
        .sign       (al_sign),
        .wdata      (wdata),
        .rdata      (bus.mem_rdata),
        .misaligned (al_mis),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (accept) state_n = al_mis ? S_RESP : S_REQ;
            S_REQ:  if (bus.mem_ack || timeout_hit) state_n = S_RESP;
            S_RESP: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            we_q      <= MEM_READ;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            off_q     <= '0;
            cnt       <= '0;
            exc_mis_q <= 1'b0;
            exc_bus_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    addr_q    <= {addr[ADDR_W-1:OW], OW'(0)};
                    be_q      <= al_be;
                    wdata_q   <= al_wdata;
                    we_q      <= is_store ? MEM_WRITE : MEM_READ;
                    size_q    <= acc.size;
                    uns_q     <= acc.uns;
                    off_q     <= addr[OW-1:0];
                    cnt       <= '0;
                    exc_mis_q <= al_mis;
                end
                S_REQ: begin
                    cnt <= cnt_inc;
                    // Ack has priority over a timeout in the same cycle.
                    if (bus.mem_ack) begin
                        rdata_q <= (we_q == MEM_WRITE) ? '0 : al_rdata;
                    end else if (timeout_hit) begin
                        exc_bus_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    rdata_q   <= '0;
                    exc_mis_q <= 1'b0;
                    exc_bus_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Bus outputs are forced low outside REQ so the port is quiet when idle.
    assign in_req        = (state == S_REQ);
    assign bus.mem_req   = in_req;
    assign bus.mem_we    = in_req & we_q;
    assign bus.mem_addr  = in_req ? addr_q : '0;
    assign bus.mem_be    = in_req ? be_q : '0;
    assign bus.mem_wdata = in_req ? wdata_q : '0;

    assign done           = (state == S_RESP);
    assign rdata          = rdata_q;
    assign exc_misaligned = exc_mis_q;
    assign exc_bus        = exc_bus_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: 32-bit and 64-bit instances
// (TIMEOUT=4), a vector table plus timeout/reset/throughput sequences.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid32, valid64, ack32, ack64;
    logic [31:0] inst, addr;
    logic [63:0] wdata, rd_in;

    mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) bus32();
    mem_access_unit_if #(.XLEN(64), .ADDR_W(32)) bus64();

    assign bus32.mem_ack   = ack32;
    assign bus32.mem_rdata = rd_in[31:0];
    assign bus64.mem_ack   = ack64;
    assign bus64.mem_rdata = rd_in;

    logic        rdy32, done32, emis32, ebus32;
    logic [31:0] rdata32;
    logic        rdy64, done64, emis64, ebus64;
    logic [63:0] rdata64;

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
        .clock(clk), .reset(rst),
        .req_valid(valid32), .req_ready(rdy32),
        .inst(inst), .addr(addr), .wdata(wdata[31:0]),
        .bus(bus32),
        .done(done32), .rdata(rdata32),
        .exc_misaligned(emis32), .exc_bus(ebus32)
    );

    mem_access_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) u64 (
        .clock(clk), .reset(rst),
        .req_valid(valid64), .req_ready(rdy64),
        .inst(inst), .addr(addr), .wdata(wdata),
        .bus(bus64),
        .done(done64), .rdata(rdata64),
        .exc_misaligned(emis64), .exc_bus(ebus64)
    );

    bit          sel64;
    logic        o_rdy, o_req, o_we, o_done, o_mis, o_bus;
    logic [7:0]  o_be;
    logic [31:0] o_ma;
    logic [63:0] o_wd, o_rd;

    always_comb begin
        if (sel64) begin
            o_rdy = rdy64; o_req = bus64.mem_req; o_we = bus64.mem_we;
            o_done = done64; o_mis = emis64; o_bus = ebus64;
            o_be = bus64.mem_be; o_ma = bus64.mem_addr;
            o_wd = bus64.mem_wdata; o_rd = rdata64;
        end else begin
            o_rdy = rdy32; o_req = bus32.mem_req; o_we = bus32.mem_we;
            o_done = done32; o_mis = emis32; o_bus = ebus32;
            o_be = {4'b0, bus32.mem_be}; o_ma = bus32.mem_addr;
            o_wd = {32'b0, bus32.mem_wdata}; o_rd = {32'b0, rdata32};
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          x64;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;
        bit          mis;
        logic [7:0]  be;
        logic [31:0] ma;
        bit          we;
        logic [63:0] ewd;
        logic [63:0] erd;
    } vec_t;

    vec_t vt[19];

    task automatic run_vec(input int i, input vec_t v);
        sel64 = v.x64;
        @(negedge clk);
        inst = v.inst; addr = v.addr; wdata = v.wd; rd_in = v.rd;
        if (v.x64) valid64 = 1'b1; else valid32 = 1'b1;
        chk($sformatf("v%0d ready", i), o_rdy, 1);
        @(negedge clk);
        valid32 = 1'b0; valid64 = 1'b0;
        if (v.mis) begin
            chk($sformatf("v%0d done", i), o_done, 1);
            chk($sformatf("v%0d exc_mis", i), o_mis, 1);
            chk($sformatf("v%0d mem_req", i), o_req, 0);
            chk($sformatf("v%0d rdata", i), o_rd, 0);
        end else begin
            chk($sformatf("v%0d mem_req", i), o_req, 1);
            chk($sformatf("v%0d mem_be", i), o_be, v.be);
            chk($sformatf("v%0d mem_addr", i), o_ma, v.ma);
            chk($sformatf("v%0d mem_we", i), o_we, v.we);
            chk($sformatf("v%0d mem_wdata", i), o_wd, v.ewd);
            chk($sformatf("v%0d early done", i), o_done, 0);
            if (v.x64) ack64 = 1'b1; else ack32 = 1'b1;
            @(negedge clk);
            ack32 = 1'b0; ack64 = 1'b0;
            chk($sformatf("v%0d done", i), o_done, 1);
            chk($sformatf("v%0d rdata", i), o_rd, v.erd);
            chk($sformatf("v%0d exc_mis", i), o_mis, 0);
            chk($sformatf("v%0d exc_bus", i), o_bus, 0);
            chk($sformatf("v%0d req drop", i), o_req, 0);
        end
        @(negedge clk);
        chk($sformatf("v%0d done end", i), o_done, 0);
        chk($sformatf("v%0d ready end", i), o_rdy, 1);
    endtask

    task automatic start32(input logic [31:0] in, input logic [31:0] ad,
                           input logic [63:0] rd);
        sel64 = 1'b0;
        @(negedge clk);
        inst = in; addr = ad; wdata = '0; rd_in = rd; valid32 = 1'b1;
        @(negedge clk);
        valid32 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [5:0] exp_done;
    logic [5:0] exp_rdy;

    initial begin
        vt[0]  = '{0, 32'h23,   32'h103, 64'hA5, 64'hDEADBEEF, 0, 8'h08, 32'h100, 1, 64'hA500_0000, 64'h0};
        vt[1]  = '{0, 32'h03,   32'h102, 64'h0, 64'h0080_0000, 0, 8'h04, 32'h100, 0, 64'h0, 64'hFFFF_FF80};
        vt[2]  = '{0, 32'h4003, 32'h102, 64'h0, 64'h0080_0000, 0, 8'h04, 32'h100, 0, 64'h0, 64'h80};
        vt[3]  = '{0, 32'h2003, 32'h102, 64'h0, 64'h0, 1, 8'h00, 32'h0, 0, 64'h0, 64'h0};
        vt[4]  = '{0, 32'h1003, 32'h102, 64'h0, 64'h8001_0000, 0, 8'h0C, 32'h100, 0, 64'h0, 64'hFFFF_8001};
        vt[5]  = '{0, 32'h5003, 32'h106, 64'h0, 64'hFFFE_1234, 0, 8'h0C, 32'h104, 0, 64'h0, 64'hFFFE};
        vt[6]  = '{0, 32'h1023, 32'h102, 64'h1234_ABCD, 64'h0, 0, 8'h0C, 32'h100, 1, 64'hABCD_0000, 64'h0};
        vt[7]  = '{0, 32'h2023, 32'h104, 64'hCAFE_F00D, 64'h1234_5678, 0, 8'h0F, 32'h104, 1, 64'hCAFE_F00D, 64'h0};
        vt[8]  = '{0, 32'h2003, 32'h108, 64'h0, 64'h8765_4321, 0, 8'h0F, 32'h108, 0, 64'h0, 64'h8765_4321};
        vt[9]  = '{0, 32'h1023, 32'h101, 64'h1111, 64'h0, 1, 8'h00, 32'h0, 0, 64'h0, 64'h0};
        vt[10] = '{1, 32'h3003, 32'h08, 64'h0, 64'h8000_0000_0000_0001, 0, 8'hFF, 32'h08, 0, 64'h0, 64'h8000_0000_0000_0001};
        vt[11] = '{1, 32'h6003, 32'h0C, 64'h0, 64'h8000_0000_0000_0001, 0, 8'hF0, 32'h08, 0, 64'h0, 64'h0000_0000_8000_0000};
        vt[12] = '{1, 32'h2003, 32'h0C, 64'h0, 64'h8000_0000_0000_0001, 0, 8'hF0, 32'h08, 0, 64'h0, 64'hFFFF_FFFF_8000_0000};
        vt[13] = '{1, 32'h3023, 32'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 8'hFF, 32'h10, 1, 64'h0123_4567_89AB_CDEF, 64'h0};
        vt[14] = '{1, 32'h0023, 32'h15, 64'hEF, 64'h0, 0, 8'h20, 32'h10, 1, 64'h0000_EF00_0000_0000, 64'h0};
        vt[15] = '{1, 32'h3003, 32'h0C, 64'h0, 64'h0, 1, 8'h00, 32'h0, 0, 64'h0, 64'h0};
        vt[16] = '{0, 32'h3003, 32'h100, 64'h0, 64'h1122_3344, 0, 8'h0F, 32'h100, 0, 64'h0, 64'h1122_3344};
        vt[17] = '{1, 32'h5003, 32'h0E, 64'h0, 64'hABCD_0000_0000_0000, 0, 8'hC0, 32'h08, 0, 64'h0, 64'hABCD};
        vt[18] = '{1, 32'h03,   32'h1F, 64'h0, 64'hFE00_0000_0000_0000, 0, 8'h80, 32'h18, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE};

        rst = 1'b1; valid32 = 1'b0; valid64 = 1'b0;
        ack32 = 1'b0; ack64 = 1'b0; sel64 = 1'b0;
        inst = '0; addr = '0; wdata = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel64 = (s == 1);
            #1;
            chk($sformatf("rst%0d ready", s), o_rdy, 1);
            chk($sformatf("rst%0d mem_req", s), o_req, 0);
            chk($sformatf("rst%0d mem_we", s), o_we, 0);
            chk($sformatf("rst%0d mem_be", s), o_be, 0);
            chk($sformatf("rst%0d mem_addr", s), o_ma, 0);
            chk($sformatf("rst%0d mem_wdata", s), o_wd, 0);
            chk($sformatf("rst%0d done", s), o_done, 0);
            chk($sformatf("rst%0d rdata", s), o_rd, 0);
            chk($sformatf("rst%0d exc", s), {o_mis, o_bus}, 0);
        end

        for (int i = 0; i < 19; i++) run_vec(i, vt[i]);

        // Non-memory opcode is ignored.
        sel64 = 1'b0;
        @(negedge clk);
        inst = 32'h0000_0013; addr = 32'h100; valid32 = 1'b1;
        @(negedge clk);
        valid32 = 1'b0;
        chk("nonmem ready", o_rdy, 1);
        chk("nonmem mem_req", o_req, 0);
        @(negedge clk);
        chk("nonmem done", o_done, 0);

        // Timeout: LH with no ack.
        start32(32'h1003, 32'h200, 64'h0);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to req c%0d", c), o_req, 1);
            chk($sformatf("to addr c%0d", c), o_ma, 32'h200);
            chk($sformatf("to be c%0d", c), o_be, 8'h03);
            chk($sformatf("to done c%0d", c), o_done, 0);
            @(negedge clk);
        end
        chk("to done", o_done, 1);
        chk("to exc_bus", o_bus, 1);
        chk("to exc_mis", o_mis, 0);
        chk("to rdata", o_rd, 0);
        chk("to req drop", o_req, 0);
        @(negedge clk);
        chk("to done end", o_done, 0);
        chk("to exc_bus end", o_bus, 0);
        chk("to ready end", o_rdy, 1);

        // Ack in the cycle the timeout is reached wins.
        start32(32'h1003, 32'h200, 64'h8000);
        repeat (3) @(negedge clk);
        chk("tie req c4", o_req, 1);
        ack32 = 1'b1;
        @(negedge clk);
        ack32 = 1'b0;
        chk("tie done", o_done, 1);
        chk("tie exc_bus", o_bus, 0);
        chk("tie rdata", o_rd, 64'hFFFF_8000);

        // Reset in the second REQ cycle, ack afterwards.
        @(negedge clk);
        start32(32'h2003, 32'h100, 64'h1234);
        @(negedge clk);
        chk("rm req c2", o_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ack32 = 1'b1;
        chk("rm done", o_done, 0);
        chk("rm mem_req", o_req, 0);
        chk("rm ready", o_rdy, 1);
        chk("rm mem_be", o_be, 0);
        @(negedge clk);
        ack32 = 1'b0;
        chk("rm late done", o_done, 0);
        chk("rm late rdata", o_rd, 0);
        chk("rm late ready", o_rdy, 1);

        // Back-to-back with ack held high: accept every 3 cycles.
        exp_done = 6'b010010;
        exp_rdy  = 6'b100100;
        sel64 = 1'b0;
        @(negedge clk);
        inst = 32'h2003; addr = 32'h100; rd_in = 64'h55;
        valid32 = 1'b1; ack32 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 5) valid32 = 1'b0;
            chk($sformatf("tp done c%0d", k + 1), o_done, exp_done[k]);
            chk($sformatf("tp ready c%0d", k + 1), o_rdy, exp_rdy[k]);
            if (exp_done[k]) chk($sformatf("tp rdata c%0d", k + 1), o_rd, 64'h55);
        end
        ack32 = 1'b0;
        @(negedge clk);
        chk("tp idle", o_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised load/store unit for the memory stage. Decodes LOAD/STORE instructions (opcode, funct3), computes byte enables, aligns store data, and sign/zero-extends load data. Drives a single-outstanding valid/ack data-memory port through a small FSM. Adds misalignment trapping and an ack timeout.

Parameters:
XLEN, 32, datapath width in bits; legal values 32 or 64. Byte-lane count is XLEN/8.
ADDR_W, 32, data-memory address width.
TIMEOUT, 255, maximum cycles waiting for mem_ack before a bus error; 0 disables the timeout.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  pipeline presents a memory-stage instruction
req_ready  out  1  unit can accept a request (high only in IDLE)
inst  in  32  instruction word; bits [6:0] opcode, [14:12] funct3
addr  in  ADDR_W  effective address from the ALU
wdata  in  XLEN  rs2 value for stores
mem_req  out  1  memory request valid
mem_we  out  1  1 = write (MEM_WRITE), 0 = read (MEM_READ)
mem_addr  out  ADDR_W  addr with the low log2(XLEN/8) bits cleared
mem_be  out  XLEN/8  byte enables
mem_wdata  out  XLEN  lane-shifted store data
mem_ack  in  1  memory completes the request; mem_rdata is valid in the same cycle
mem_rdata  in  XLEN  read data
done  out  1  one-cycle completion pulse
rdata  out  XLEN  extended load result; valid while done is high
exc_misaligned  out  1  with done: misaligned access, no memory request issued
exc_bus  out  1  with done: ack timeout

Behaviour:
- Reset: state IDLE. req_ready=1. mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, done=0, rdata=0, exc_*=0, wait counter=0.
- Acceptance: a request is accepted when req_valid && req_ready. Any opcode other than LOAD or STORE is ignored and the unit stays in IDLE.
- Size decode from funct3:
  - B/BU = 1 byte; H/HU = 2 bytes; W/WU = 4 bytes; D = 8 bytes (XLEN=64 only).
  - Unsupported funct3 for XLEN is treated as W.
  - Unsigned variants (BU/HU/WU) are loads only; the store path uses funct3[1:0].
- Misalignment: addr mod size != 0. The unit goes to RESP with exc_misaligned=1 and never asserts mem_req.
- mem_be: contiguous ones of length size, shifted left by addr low bits. mem_wdata is wdata replicated/shifted to the same lanes.
- States:
  - IDLE: on an accepted aligned request, latch addr/size/sign/we and go to REQ. mem_req rises the next cycle, so issue latency is 1 cycle.
  - REQ: mem_req and all mem_* outputs are held stable until mem_ack. Counter increments each cycle.
    - On mem_ack: capture and extend mem_rdata (shift right by lane, sign or zero extend to XLEN; stores give rdata=0), go to RESP.
    - On counter==TIMEOUT with TIMEOUT!=0: drop mem_req, set exc_bus, go to RESP.
    - If mem_ack arrives in the same cycle the timeout is reached, the ack wins.
  - RESP: done=1 for exactly one cycle, then IDLE. req_ready returns to 1 on the following cycle.
- Throughput: with mem_ack in the first REQ cycle, done fires 2 cycles after acceptance, and a new request can be accepted every 3 cycles.
- mem_req is deasserted in the cycle after ack.
- Reset mid-transaction: abort immediately to IDLE with all outputs at reset values. No done pulse is produced for the aborted access.
- mem_ack outside REQ is ignored.

Decomposition:
- Shared package/include (existing codes file): opcodes LOAD/STORE; funct3 codes LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD; MEM_READ/MEM_WRITE; state encodings.
- One combinational sub-module, mem_lane_align: size/offset → byte enables, store shift, and load extract/extend. Reused by any future cache.

Test Plan:
- XLEN=32, SB to addr 0x103, wdata=0x000000A5, ack in the first REQ cycle → mem_be=4'b1000, mem_wdata[31:24]=0xA5, mem_addr=0x100, mem_we=1, done 2 cycles after acceptance.
- LB from 0x102, mem_rdata=0x0080_0000 → rdata=0xFFFF_FF80. Same access as LBU → rdata=0x0000_0080.
- LW from 0x102 → exc_misaligned=1 and done in cycle +1; mem_req stays 0 throughout.
- TIMEOUT=4, LH from 0x200 with no ack → mem_req high for 4 cycles, then done with exc_bus=1 and rdata=0.
- Reset asserted in the 2nd REQ cycle, then ack arrives → no done pulse, mem_req=0 the next cycle, req_ready=1.
- XLEN=64, LD from 0x08, mem_rdata=0x8000_0000_0000_0001 → mem_be=8'hFF, rdata equals mem_rdata. LWU from 0x0C with the same data → rdata=0x0000_0000_8000_0000.
